store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write FIFO between the write-through data cache and data_mem.
//  Absorbs sw/sh/sb stores so the cache does not stall on memory latency.
//  Serves cache read-miss refills, ordering them against pending stores to the same word.
//  Single memory port with valid/ready handshake; one transaction in flight at a time.
// PARAMETERS
//  ADDR_WIDTH  32  address width
//  DATA_WIDTH  32  data width
//  DEPTH       4   store entries; must be a power of 2 and >= 2
// PORTS
//  clk        in   1           clock
//  rst        in   1           synchronous active-high reset
//  wr_valid   in   1           cache posts a store
//  wr_ready   out  1           store accepted this cycle (= !full, 0 while rst)
//  wr_addr    in   ADDR_WIDTH  store byte address
//  wr_data    in   DATA_WIDTH  store data (byte modes use [7:0])
//  wr_mode    in   3           addr_mode (DATA_ADDR_MODE_*), passed through unchanged
//  rd_valid   in   1           refill request; held until rd_done
//  rd_addr    in   ADDR_WIDTH  refill byte address
//  rd_done    out  1           1-cycle pulse: rd_data valid
//  rd_data    out  DATA_WIDTH  refill word
//  mem_valid  out  1           memory request valid
//  mem_we     out  1           1 = write, 0 = read
//  mem_addr   out  ADDR_WIDTH  memory address
//  mem_wdata  out  DATA_WIDTH  memory write data
//  mem_mode   out  3           memory addr_mode
//  mem_ready  in   1           memory accepts the request; for reads, mem_rdata is valid this cycle
//  mem_rdata  in   DATA_WIDTH  memory read data
//  count      out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  FIFO: entries hold {addr, data, mode}.
//   - Push when wr_valid && wr_ready.
//   - rd_ptr/wr_ptr are $clog2(DEPTH) bits and wrap naturally.
//   - count increments on push and decrements on pop; both in the same cycle leaves it unchanged.
//   - wr_ready = (count != DEPTH); a pop in the same cycle does not open a slot while full.
//  Hazard (comb): any occupied entry with addr[AW-1:2] == rd_addr[AW-1:2].
//   - Comparison is on the word address, so byte stores to any byte of the word match.
//  FSM states IDLE, DRAIN, READ. Decisions are taken in IDLE only.
//   - IDLE: if rd_valid && !hazard -> READ; latch rd_addr into mem_addr.
//     Else if count != 0 -> DRAIN; latch the head entry onto mem_*.
//     Else stay in IDLE. A clean read has priority over draining.
//   - DRAIN: mem_valid=1, mem_we=1.
//     On mem_ready: pop the head, return to IDLE.
//   - READ: mem_valid=1, mem_we=0.
//     On mem_ready: rd_data <= mem_rdata, rd_done=1 next cycle, return to IDLE.
//  mem_addr/wdata/mode/we are registered and held stable while mem_valid=1.
//  mem_valid=0 in IDLE.
//  Latency:
//   - Read with no hazard, rd_valid at cycle N, mem_ready at N+1: rd_done at N+2.
//   - Store pushed at edge N: earliest mem_valid for it is N+2.
//  Progress: a hazarding read waits while the stores drain in order; it cannot starve.
//  The requester keeps rd_valid/rd_addr stable until rd_done.
//   - A rd_valid still high in the rd_done cycle is treated as a new request.
//  Reset values: state=IDLE, ptrs=0, count=0, mem_valid=0, mem_we=0, mem_*=0, rd_done=0, rd_data=0.
//  Reset mid-transaction abandons the in-flight request; queued stores are discarded.
// TESTING
//  1. With mem_ready=0, push 0x100/0x104/0x108/0x10C, then attempt a 5th push.
//     -> count=4, wr_ready=0, 5th push dropped.
//     Then mem_ready=1 -> 4 writes issued in order, count reaches 0.
//  2. Push sw 0x200=0xDEADBEEF, then rd_valid 0x200 on the next cycle.
//     -> write beat first, then read beat; rd_done with rd_data=0xDEADBEEF.
//  3. Buffer holds store 0x300; rd_valid 0x400.
//     -> first mem beat is mem_we=0, addr 0x400; the store drains afterwards.
//  4. Push sb 0x203=0xAA; rd_valid 0x200.
//     -> hazard detected; write drains before the read; the read returns byte3=0xAA.
//  5. DEPTH=4, 10 pushes interleaved with random mem_ready.
//     -> memory sees all 10 in order, count<=4, pointers wrap correctly.
//  6. rst pulsed in DRAIN with mem_ready=0.
//     -> next cycle mem_valid=0, count=0, rd_done=0; wr_ready=1 after rst deasserts.

Source files
------------

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Posted-write FIFO between the write-through data cache and data_mem.
// The cache hands stores (sw/sh/sb) to this block and carries on. The block
// then drains them to memory in order through one valid/ready port. The same
// port also serves cache refill reads. A refill that touches a word with a
// pending store waits until the store reaches memory, so it never returns
// stale data. Only one memory transaction is in flight at a time.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   wr_valid/wr_ready     store handshake (wr_ready = not full, 0 during rst)
//   wr_addr/wr_data/wr_mode  store byte address, data, addr_mode (passed through)
//   rd_valid/rd_addr      refill request, held by the requester until rd_done
//   rd_done/rd_data       one-cycle completion pulse with the refill word
//   mem_valid/mem_we      memory request valid, 1 = write / 0 = read
//   mem_addr/mem_wdata/mem_mode  registered request fields, stable while valid
//   mem_ready/mem_rdata   memory accept; read data is valid in the accept cycle
//   count                 number of occupied store entries
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [2:0]                wr_mode,
    input  logic                      rd_valid,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic                      rd_done,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      mem_valid,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [2:0]                mem_mode,
    input  logic                      mem_ready,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    // Controller state
    state_t                  state_q,     state_d;
    logic [PW-1:0]           rd_ptr_q,    rd_ptr_d;
    logic [PW-1:0]           wr_ptr_q,    wr_ptr_d;
    logic [CW-1:0]           count_q,     count_d;

    // Store entries
    logic [ADDR_WIDTH-1:0]   fifo_addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_addr_d [DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data_q [DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data_d [DEPTH];
    logic [2:0]              fifo_mode_q [DEPTH];
    logic [2:0]              fifo_mode_d [DEPTH];

    // Registered memory-side and read-return outputs
    logic                    mem_valid_q, mem_valid_d;
    logic                    mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [2:0]              mem_mode_q,  mem_mode_d;
    logic                    rd_done_q,   rd_done_d;
    logic [DATA_WIDTH-1:0]   rd_data_q,   rd_data_d;

    // Per-cycle events
    logic                    wr_ready_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    hazard_s;

    // Accept a store only when a slot is free. A pop in the same cycle
    // does not count, which keeps the full check a plain compare on count_q.
    always_comb begin
        wr_ready_s = (!rst) && (count_q != CW'(DEPTH));
        push_s     = wr_valid && wr_ready_s;
    end

    // Hazard check: a refill must not pass a queued store to the same word.
    // An entry is occupied when its distance from the head is below count.
    // The compare ignores the byte offset, so sb/sh to any byte of the word hit.
    always_comb begin : hazard_blk
        logic [PW-1:0] offset_v;
        hazard_s = 1'b0;
        offset_v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset_v = PW'(i) - rd_ptr_q;
            if ((CW'(offset_v) < count_q) &&
                (fifo_addr_q[i][ADDR_WIDTH-1:2] == rd_addr[ADDR_WIDTH-1:2])) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    // Next-state logic for the controller and the memory request registers.
    // Decisions are taken only in IDLE. A non-conflicting read goes ahead of
    // draining, and a conflicting read waits until the stores ahead of it leave.
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_mode_d  = mem_mode_q;
        rd_data_d   = rd_data_q;
        rd_done_d   = 1'b0;
        pop_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rd_valid && !hazard_s) begin
                    state_d     = ST_READ;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = rd_addr;
                end else if (count_q != {CW{1'b0}}) begin
                    state_d     = ST_DRAIN;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = fifo_addr_q[rd_ptr_q];
                    mem_wdata_d = fifo_data_q[rd_ptr_q];
                    mem_mode_d  = fifo_mode_q[rd_ptr_q];
                end else begin
                    state_d     = ST_IDLE;
                    mem_valid_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (mem_ready) begin
                    pop_s       = 1'b1;
                    state_d     = ST_IDLE;
                    mem_valid_d = 1'b0;
                end else begin
                    state_d     = ST_DRAIN;
                end
            end
            ST_READ: begin
                if (mem_ready) begin
                    rd_data_d   = mem_rdata;
                    rd_done_d   = 1'b1;
                    state_d     = ST_IDLE;
                    mem_valid_d = 1'b0;
                end else begin
                    state_d     = ST_READ;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // FIFO pointers and occupancy. The pointers are exactly log2(DEPTH) bits,
    // so they wrap on their own.
    always_comb begin
        rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry storage next values: write the tail slot on push.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_s && (wr_ptr_q == PW'(i))) begin
                fifo_addr_d[i] = wr_addr;
                fifo_data_d[i] = wr_data;
                fifo_mode_d[i] = wr_mode;
            end else begin
                fifo_addr_d[i] = fifo_addr_q[i];
                fifo_data_d[i] = fifo_data_q[i];
                fifo_mode_d[i] = fifo_mode_q[i];
            end
        end
    end

    // State register. Reset drops any in-flight request and empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mode_q  <= 3'd0;
            rd_done_q   <= 1'b0;
            rd_data_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
                fifo_mode_q[i] <= 3'd0;
            end
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_mode_q  <= mem_mode_d;
            rd_done_q   <= rd_done_d;
            rd_data_q   <= rd_data_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= fifo_addr_d[i];
                fifo_data_q[i] <= fifo_data_d[i];
                fifo_mode_q[i] <= fifo_mode_d[i];
            end
        end
    end

    assign wr_ready  = wr_ready_s;
    assign rd_done   = rd_done_q;
    assign rd_data   = rd_data_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_mode  = mem_mode_q;
    assign count     = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Directed bench for store_buffer (DEPTH=4). A small memory model answers the
// memory port. Reads of a word that was never written return {16'h5A5A,
// addr[15:0]}. Writes honour byte, half and word modes. Every memory beat is
// logged so the order of the beats can be checked against hand-written values.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam logic [2:0] MODE_B = 3'd0;
    localparam logic [2:0] MODE_H = 3'd1;
    localparam logic [2:0] MODE_W = 3'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  wr_mode;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic        rd_done;
    logic [31:0] rd_data;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_mode;
    logic        mem_ready;
    logic [31:0] mem_rdata = 32'h0;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    // Beat log, written only by the monitor
    logic        b_we   [0:127];
    logic [31:0] b_addr [0:127];
    logic [31:0] b_data [0:127];
    logic [2:0]  b_mode [0:127];
    int          beat_n = 0;

    logic [31:0] model [int unsigned];

    store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mode(wr_mode),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mode(mem_mode),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned idx;
        idx = int'(a[31:2]);
        if (model.exists(idx)) return model[idx];
        else return {16'h5A5A, a[15:2], 2'b00};
    endfunction

    // Memory model and beat logger
    always @(posedge clk) begin
        if (mem_valid && mem_ready) begin
            if (beat_n < 128) begin
                b_we[beat_n]   = mem_we;
                b_addr[beat_n] = mem_addr;
                b_data[beat_n] = mem_we ? mem_wdata : mem_rdata;
                b_mode[beat_n] = mem_mode;
            end
            beat_n = beat_n + 1;
            if (mem_we) begin : wr_blk
                logic [31:0] w;
                w = model_read(mem_addr);
                case (mem_mode)
                    MODE_B:  w[8*mem_addr[1:0] +: 8] = mem_wdata[7:0];
                    MODE_H:  w[16*mem_addr[1] +: 16] = mem_wdata[15:0];
                    default: w = mem_wdata;
                endcase
                model[int'(mem_addr[31:2])] = w;
            end
        end
    end

    // Read data is presented mid-cycle from the address the DUT holds
    always @(negedge clk) mem_rdata = model_read(mem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_mode  = m;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_rd_done();
        for (int i = 0; i < 30 && !rd_done; i++) tick();
    endtask

    initial begin
        int base;
        int k;
        logic acc;

        rst = 1'b1; wr_valid = 1'b0; wr_addr = 32'h0; wr_data = 32'h0; wr_mode = MODE_W;
        rd_valid = 1'b0; rd_addr = 32'h0; mem_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_count", count, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wr_ready_low", wr_ready, 0);
        rst = 1'b0;
        tick();
        check("post_rst_wr_ready", wr_ready, 1);

        // 1: fill with memory stalled, overflow attempt, then drain in order
        base = beat_n;
        push(32'h100, 32'hA000_0100, MODE_W);
        check("t1_no_valid_yet", mem_valid, 0);
        check("t1_count1", count, 1);
        push(32'h104, 32'hA000_0104, MODE_W);
        check("t1_valid_at_n2", mem_valid, 1);
        check("t1_head_addr", mem_addr, 32'h100);
        check("t1_head_we", mem_we, 1);
        push(32'h108, 32'hA000_0108, MODE_W);
        push(32'h10C, 32'hA000_010C, MODE_W);
        check("t1_full_count", count, 4);
        check("t1_full_wr_ready", wr_ready, 0);
        push(32'h110, 32'hA000_0110, MODE_W);
        check("t1_drop_count", count, 4);
        check("t1_held_wdata", mem_wdata, 32'hA000_0100);
        mem_ready = 1'b1;
        for (int i = 0; i < 40 && count != 3'd0; i++) tick();
        tick(); tick(); tick();
        check("t1_drained", count, 0);
        check("t1_beats", beat_n - base, 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_beat_we", b_we[base+i], 1);
            check("t1_beat_addr", b_addr[base+i], 32'h100 + 32'(4*i));
            check("t1_beat_data", b_data[base+i], 32'hA000_0100 + 32'(4*i));
        end

        // 2: store then same-word read, write goes first
        base = beat_n;
        push(32'h200, 32'hDEAD_BEEF, MODE_W);
        rd_valid = 1'b1; rd_addr = 32'h200;
        wait_rd_done();
        check("t2_rd_done", rd_done, 1);
        rd_valid = 1'b0;
        check("t2_rd_data", rd_data, 32'hDEAD_BEEF);
        check("t2_beats", beat_n - base, 2);
        check("t2_b0_we", b_we[base], 1);
        check("t2_b0_addr", b_addr[base], 32'h200);
        check("t2_b1_we", b_we[base+1], 0);
        check("t2_b1_addr", b_addr[base+1], 32'h200);
        tick();
        check("t2_done_pulse", rd_done, 0);

        // 3: clean read overtakes a queued store; latency N -> N+2
        base = beat_n;
        wr_valid = 1'b1; wr_addr = 32'h300; wr_data = 32'h3333_3333; wr_mode = MODE_W;
        rd_valid = 1'b1; rd_addr = 32'h400;
        tick();
        wr_valid = 1'b0;
        check("t3_rd_valid_beat", mem_valid, 1);
        check("t3_rd_we", mem_we, 0);
        check("t3_rd_addr", mem_addr, 32'h400);
        check("t3_no_done_n1", rd_done, 0);
        check("t3_count", count, 1);
        tick();
        check("t3_done_n2", rd_done, 1);
        check("t3_rd_data", rd_data, 32'h5A5A_0400);
        rd_valid = 1'b0;
        tick();
        check("t3_done_pulse", rd_done, 0);
        for (int i = 0; i < 20 && (beat_n - base) < 2; i++) tick();
        check("t3_beats", beat_n - base, 2);
        check("t3_b0_we", b_we[base], 0);
        check("t3_b1_we", b_we[base+1], 1);
        check("t3_b1_addr", b_addr[base+1], 32'h300);
        check("t3_b1_data", b_data[base+1], 32'h3333_3333);

        // 4: byte store to byte 3, refill of the word sees it
        base = beat_n;
        push(32'h203, 32'h0000_00AA, MODE_B);
        rd_valid = 1'b1; rd_addr = 32'h200;
        wait_rd_done();
        check("t4_rd_done", rd_done, 1);
        rd_valid = 1'b0;
        check("t4_rd_data", rd_data, 32'hAAAD_BEEF);
        check("t4_b0_we", b_we[base], 1);
        check("t4_b0_addr", b_addr[base], 32'h203);
        check("t4_b0_mode", b_mode[base], MODE_B);
        check("t4_b1_we", b_we[base+1], 0);
        tick();

        // 5: ten pushes against a randomly stalling memory
        base = beat_n;
        k = 0;
        for (int c = 0; c < 600 && !(k == 10 && (beat_n - base) >= 10); c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            if (k < 10) begin
                wr_valid = 1'b1; wr_addr = 32'h500 + 32'(4*k);
                wr_data = 32'h1000 + 32'(k); wr_mode = MODE_W;
            end else begin
                wr_valid = 1'b0;
            end
            acc = wr_valid && wr_ready;
            tick();
            if (acc) k++;
            check("t5_count_le_depth", (count <= 3'd4), 1);
        end
        wr_valid = 1'b0;
        mem_ready = 1'b1;
        tick(); tick();
        check("t5_pushed", k, 10);
        check("t5_beats", beat_n - base, 10);
        check("t5_count_end", count, 0);
        for (int i = 0; i < 10; i++) begin
            check("t5_beat_addr", b_addr[base+i], 32'h500 + 32'(4*i));
            check("t5_beat_data", b_data[base+i], 32'h1000 + 32'(i));
        end

        // 6: reset while draining with memory stalled
        mem_ready = 1'b0;
        push(32'h600, 32'h6666_0000, MODE_W);
        push(32'h604, 32'h6666_0004, MODE_W);
        check("t6_in_drain", mem_valid, 1);
        rst = 1'b1;
        tick();
        check("t6_rst_mem_valid", mem_valid, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_rd_done", rd_done, 0);
        check("t6_rst_wr_ready", wr_ready, 0);
        rst = 1'b0;
        mem_ready = 1'b1;
        base = beat_n;
        tick();
        check("t6_wr_ready", wr_ready, 1);
        tick(); tick(); tick(); tick();
        check("t6_no_stale_beats", beat_n - base, 0);
        check("t6_idle_valid", mem_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
